// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the SR latch command driver.
// Contents: FSM state encoding and the set/reset command literals.
// Imported by sr_latch_driver and sr_phase_cnt.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  localparam logic CMD_SET = 1'b1;
  localparam logic CMD_RST = 1'b0;

endpackage : sr_drv_pkg

// File: rtl/sr_phase_cnt.sv
// Loadable down-counter timing the GUARD and DRIVE windows of the driver.
// Ports: clk_i/rst_i (sync active-high), load_i/load_val_i load a start value,
//        dec_i decrements, zero_o flags a count of zero (last cycle of a window).
module sr_phase_cnt
  import sr_drv_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule : sr_phase_cnt

// File: rtl/sr_latch_driver.sv
// Command stage for a gated NOR SR latch: accepts set/reset requests on a
// valid/ready handshake, drives s or r with en for HOLD_CYC cycles, inserts a
// GUARD_CYC gap before a direction change, and tracks the expected latch value.
// Ports: clk/rst (sync active-high), cmd_valid/cmd_set/cmd_ready handshake,
//        s/r/en latch drive, busy, q_exp/q_exp_vld expected latch state.
// Optional: SR_READBACK_CHECK_EN adds q_fb input and sticky chk_err output.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int HOLD_CYC  = 2,
  parameter int GUARD_CYC = 1,
  parameter int CNT_W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic cmd_set,
  output logic cmd_ready,
  output logic s,
  output logic r,
  output logic en,
  output logic busy,
  output logic q_exp,
  output logic q_exp_vld
`ifdef SR_READBACK_CHECK_EN
  ,
  input  logic q_fb,
  output logic chk_err
`endif
);

  // Counter start values: a window of N cycles counts N-1 down to 0.
  localparam logic             GUARD_EN = (GUARD_CYC > 0);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);

  state_e state_q, state_d;
  logic   cmd_q, cmd_d;
  logic   last_cmd_q, last_cmd_d;
  logic   last_vld_q, last_vld_d;
  logic   q_exp_q, q_exp_d;
  logic   q_exp_vld_q, q_exp_vld_d;
  logic   s_q, r_q, en_q, busy_q, rdy_q;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             drive_done;

  sr_phase_cnt #(
    .CNT_W (CNT_W)
  ) u_phase_cnt (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    last_cmd_d   = last_cmd_q;
    last_vld_d   = last_vld_q;
    q_exp_d      = q_exp_q;
    q_exp_vld_d  = q_exp_vld_q;
    cnt_load     = 1'b0;
    cnt_load_val = HOLD_LD;
    cnt_dec      = 1'b0;
    drive_done   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_d    = cmd_set;
          cnt_load = 1'b1;
          // Only a direction change after a completed command needs the gap,
          // so the latch inputs never switch s->r (or r->s) without idle time.
          if (GUARD_EN && last_vld_q && (cmd_set != last_cmd_q)) begin
            state_d      = ST_GUARD;
            cnt_load_val = GUARD_LD;
          end else begin
            state_d      = ST_DRIVE;
            cnt_load_val = HOLD_LD;
          end
        end
      end
      ST_GUARD: begin
        if (cnt_zero) begin
          state_d      = ST_DRIVE;
          cnt_load     = 1'b1;
          cnt_load_val = HOLD_LD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (cnt_zero) begin
          state_d     = ST_IDLE;
          drive_done  = 1'b1;
          q_exp_d     = cmd_q;
          q_exp_vld_d = 1'b1;
          last_cmd_d  = cmd_q;
          last_vld_d  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are flopped from the next-state decode so they line up with
  // state_q; s and r are mutually exclusive because both derive from one cmd_d.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_RST;
      last_cmd_q  <= CMD_RST;
      last_vld_q  <= 1'b0;
      q_exp_q     <= 1'b0;
      q_exp_vld_q <= 1'b0;
      s_q         <= 1'b0;
      r_q         <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      rdy_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      last_cmd_q  <= last_cmd_d;
      last_vld_q  <= last_vld_d;
      q_exp_q     <= q_exp_d;
      q_exp_vld_q <= q_exp_vld_d;
      s_q         <= (state_d == ST_DRIVE) && (cmd_d == CMD_SET);
      r_q         <= (state_d == ST_DRIVE) && (cmd_d == CMD_RST);
      en_q        <= (state_d == ST_DRIVE);
      busy_q      <= (state_d != ST_IDLE);
      rdy_q       <= (state_d == ST_IDLE);
    end
  end

  assign s         = s_q;
  assign r         = r_q;
  assign en        = en_q;
  assign busy      = busy_q;
  assign cmd_ready = rdy_q;
  assign q_exp     = q_exp_q;
  assign q_exp_vld = q_exp_vld_q;

`ifdef SR_READBACK_CHECK_EN
  // Compare in the first IDLE cycle after DRIVE, when q_exp has just been
  // updated and the latch has had the whole hold window to settle.
  logic chk_pend_q;
  logic chk_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_pend_q <= 1'b0;
      chk_err_q  <= 1'b0;
    end else begin
      chk_pend_q <= drive_done;
      if (chk_pend_q && (q_fb != q_exp_q)) begin
        chk_err_q <= 1'b1;
      end
    end
  end

  assign chk_err = chk_err_q;
`endif

endmodule : sr_latch_driver

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver driving a behavioural gated NOR SR latch.
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
// Define SR_READBACK_CHECK_EN to also exercise the readback checker.
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_set = 1'b0;
  logic rdy_w, s_w, r_w, en_w, busy_w, qexp_w, qvld_w;
  logic latch_q;
  int   checks = 0;
  int   failures = 0;

  wire [4:0] outs = {s_w, r_w, en_w, busy_w, rdy_w};

  always #5 clk = ~clk;

`ifdef SR_READBACK_CHECK_EN
  logic force_fb = 1'b0;
  logic chk_err_w;
  wire  q_fb_w = force_fb ? 1'b0 : latch_q;
`endif

  sr_latch_driver dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_set   (cmd_set),
    .cmd_ready (rdy_w),
    .s         (s_w),
    .r         (r_w),
    .en        (en_w),
    .busy      (busy_w),
    .q_exp     (qexp_w),
    .q_exp_vld (qvld_w)
`ifdef SR_READBACK_CHECK_EN
    ,
    .q_fb      (q_fb_w),
    .chk_err   (chk_err_w)
`endif
  );

  // Gated NOR SR latch: transparent while en is high.
  always_latch begin
    if (en_w) begin
      if (s_w) latch_q = 1'b1;
      else if (r_w) latch_q = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (outs !== 5'b00001) begin
      failures++; $display("FAIL reset_outs got=%b exp=%b", outs, 5'b00001);
    end
    checks++;
    if ({qexp_w, qvld_w} !== 2'b00) begin
      failures++; $display("FAIL reset_qexp got=%b exp=%b", {qexp_w, qvld_w}, 2'b00);
    end
`ifdef SR_READBACK_CHECK_EN
    checks++;
    if (chk_err_w !== 1'b0) begin
      failures++; $display("FAIL reset_chk_err got=%b exp=0", chk_err_w);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_set();
    cmd_valid = 1'b1; cmd_set = 1'b1;
    step();
    cmd_valid = 1'b0;
    checks++;
    if (outs !== 5'b10110) begin
      failures++; $display("FAIL set_c1 got=%b exp=%b", outs, 5'b10110);
    end
    step();
    checks++;
    if (outs !== 5'b10110) begin
      failures++; $display("FAIL set_c2 got=%b exp=%b", outs, 5'b10110);
    end
    step();
    checks++;
    if ({outs, qexp_w, qvld_w, latch_q} !== 8'b00001_111) begin
      failures++; $display("FAIL set_c3 got=%b exp=%b", {outs, qexp_w, qvld_w, latch_q}, 8'b00001_111);
    end
  endtask

  task automatic test_set_reset();
    cmd_valid = 1'b1; cmd_set = 1'b0;
    step();
    cmd_valid = 1'b0;
    checks++;
    if (outs !== 5'b00010) begin
      failures++; $display("FAIL guard_c1 got=%b exp=%b", outs, 5'b00010);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (outs !== 5'b01110) begin
        failures++; $display("FAIL rst_drive_c%0d got=%b exp=%b", i + 2, outs, 5'b01110);
      end
    end
    step();
    checks++;
    if ({outs, qexp_w, qvld_w, latch_q} !== 8'b00001_010) begin
      failures++; $display("FAIL rst_done got=%b exp=%b", {outs, qexp_w, qvld_w, latch_q}, 8'b00001_010);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_s;
    logic [5:0] exp_rdy;
    exp_s   = 6'b011011;
    exp_rdy = 6'b100100;
    // Restore last command = set (guard + 2 drive + idle).
    cmd_valid = 1'b1; cmd_set = 1'b1;
    step();
    cmd_valid = 1'b0;
    step(); step(); step();
    cmd_valid = 1'b1; cmd_set = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if ({s_w, r_w, en_w, rdy_w} !== {exp_s[i], 1'b0, exp_s[i], exp_rdy[i]}) begin
        failures++;
        $display("FAIL b2b_c%0d got=%b exp=%b", i + 1, {s_w, r_w, en_w, rdy_w},
                 {exp_s[i], 1'b0, exp_s[i], exp_rdy[i]});
      end
      if (i == 4) cmd_valid = 1'b0;
    end
  endtask

  task automatic test_ignore();
    cmd_valid = 1'b1; cmd_set = 1'b1;
    step();
    cmd_set = 1'b0;  // not ready: must be ignored, not buffered
    checks++;
    if (outs !== 5'b10110) begin
      failures++; $display("FAIL ign_c1 got=%b exp=%b", outs, 5'b10110);
    end
    step();
    cmd_valid = 1'b0;
    checks++;
    if (outs !== 5'b10110) begin
      failures++; $display("FAIL ign_c2 got=%b exp=%b", outs, 5'b10110);
    end
    step();
    step();
    checks++;
    if ({outs, qexp_w} !== 6'b00001_1) begin
      failures++; $display("FAIL ign_c4 got=%b exp=%b", {outs, qexp_w}, 6'b00001_1);
    end
  endtask

  task automatic test_rst_mid();
    cmd_valid = 1'b1; cmd_set = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    checks++;
    if (outs !== 5'b01110) begin
      failures++; $display("FAIL mid_drive got=%b exp=%b", outs, 5'b01110);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({outs, qexp_w, qvld_w} !== 7'b00001_00) begin
      failures++; $display("FAIL mid_rst got=%b exp=%b", {outs, qexp_w, qvld_w}, 7'b00001_00);
    end
    // First command after reset takes no guard even though it opposes the
    // last command completed before reset.
    cmd_valid = 1'b1; cmd_set = 1'b0;
    step();
    cmd_valid = 1'b0;
    checks++;
    if (outs !== 5'b01110) begin
      failures++; $display("FAIL first_no_guard got=%b exp=%b", outs, 5'b01110);
    end
    step(); step();
    checks++;
    if ({outs, qexp_w, qvld_w, latch_q} !== 8'b00001_010) begin
      failures++; $display("FAIL first_done got=%b exp=%b", {outs, qexp_w, qvld_w, latch_q}, 8'b00001_010);
    end
  endtask

  task automatic test_random_invariant();
    int bad;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_set   = 1'($urandom_range(0, 1));
      step();
      checks++;
      if ((s_w & r_w) || ((s_w | r_w) && !en_w) || (en_w && !busy_w)) begin
        failures++; bad++;
        if (bad < 5) $display("FAIL invariant cyc=%0d got srenbusy=%b%b%b%b exp s&r=0", i, s_w, r_w, en_w, busy_w);
      end
    end
    cmd_valid = 1'b0;
    step(); step(); step(); step();
  endtask

`ifdef SR_READBACK_CHECK_EN
  task automatic test_readback();
    checks++;
    if (chk_err_w !== 1'b0) begin
      failures++; $display("FAIL rb_no_false_err got=%b exp=0", chk_err_w);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    force_fb = 1'b1;
    cmd_valid = 1'b1; cmd_set = 1'b1;
    step();
    cmd_valid = 1'b0;
    step(); step();
    checks++;
    if (chk_err_w !== 1'b0) begin
      failures++; $display("FAIL rb_before got=%b exp=0", chk_err_w);
    end
    step();
    checks++;
    if (chk_err_w !== 1'b1) begin
      failures++; $display("FAIL rb_set got=%b exp=1", chk_err_w);
    end
    force_fb = 1'b0;
    step(); step(); step();
    checks++;
    if (chk_err_w !== 1'b1) begin
      failures++; $display("FAIL rb_sticky got=%b exp=1", chk_err_w);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (chk_err_w !== 1'b0) begin
      failures++; $display("FAIL rb_clear got=%b exp=0", chk_err_w);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_set();
    test_set_reset();
    test_back_to_back();
    test_ignore();
    test_rst_mid();
    test_random_invariant();
`ifdef SR_READBACK_CHECK_EN
    test_readback();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sr_latch_driver
